// File: rtl/cache_miss_ctrl.sv
// -----------------------------------------------------------------------------
// cache_miss_ctrl
//   Control path for a 2-way set-associative, write-back cache with 16-byte
//   lines. Hits complete in the same cycle they are presented (Mealy decode in
//   IDLE). A miss picks the LRU way as victim. If the victim is dirty, the line
//   is written back first (WRITEBACK). The new line is then fetched (ALLOCATE).
//   The request then completes as an ordinary hit back in IDLE.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   mem_read, mem_write          CPU request (held until mem_resp); both = write
//   mem_address[15:0]            CPU byte address {tag, index, offset}
//   mem_resp                     one-cycle request-complete pulse
//   hit0/hit1, dirty0/dirty1     per-way hit and dirty status at current index
//   tag0/tag1                    per-way stored tags at current index
//   lru_of_set                   victim select from the LRU tracker (1 = way 1)
//   load_lru, set_one_hit,       LRU update strobe and which way was accessed
//   set_two_hit
//   load_way0/load_way1          install fetched line (data, tag, valid, clean)
//   set_dirty0/set_dirty1        mark way dirty on a write hit
//   wb_way                       way whose data drives pmem_wdata
//   pmem_read, pmem_write,       physical memory request, completed by
//   pmem_address, pmem_resp      pmem_resp
//   hit_count, miss_count        saturating statistics counters
// -----------------------------------------------------------------------------
module cache_miss_ctrl #(
  parameter int TAG_W   = 9,
  parameter int INDEX_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [15:0]       mem_address,
  output logic              mem_resp,
  input  logic              hit0,
  input  logic              hit1,
  input  logic              dirty0,
  input  logic              dirty1,
  input  logic [TAG_W-1:0]  tag0,
  input  logic [TAG_W-1:0]  tag1,
  input  logic              lru_of_set,
  output logic              load_lru,
  output logic              set_one_hit,
  output logic              set_two_hit,
  output logic              load_way0,
  output logic              load_way1,
  output logic              set_dirty0,
  output logic              set_dirty1,
  output logic              wb_way,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [15:0]       pmem_address,
  input  logic              pmem_resp,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
);

  localparam int OFFSET_W = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               victim_q;
  logic [TAG_W-1:0]   victim_tag_q;
  logic               hit_done;
  logic               miss_done;

  logic               req;
  logic               victim_dirty;
  logic [INDEX_W-1:0] index;
  logic               unused_offset;

  assign req          = mem_read | mem_write;
  assign victim_dirty = lru_of_set ? dirty1 : dirty0;
  assign index        = mem_address[INDEX_W+OFFSET_W-1:OFFSET_W];
  // Byte offset plays no part in line-granular control.
  assign unused_offset = ^mem_address[OFFSET_W-1:0];

  // NOTE: async reset belongs in the sensitivity list; state uses <= only so
  // every register samples the pre-edge values of its inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      victim_q     <= 1'b0;
      victim_tag_q <= '0;
      hit_count    <= '0;
      miss_count   <= '0;
    end else begin
      state_q <= state_d;
      // Victim and its tag are frozen at the miss decision so the writeback
      // address cannot drift if the tag array outputs change meanwhile.
      if (miss_done) begin
        victim_q     <= lru_of_set;
        victim_tag_q <= lru_of_set ? tag1 : tag0;
      end
      if (hit_done && hit_count != 16'hFFFF) begin
        hit_count <= hit_count + 16'd1;
      end
      if (miss_done && miss_count != 16'hFFFF) begin
        miss_count <= miss_count + 16'd1;
      end
    end
  end

  // NOTE: every output of this block gets a default first so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    mem_resp     = 1'b0;
    load_lru     = 1'b0;
    set_one_hit  = 1'b0;
    set_two_hit  = 1'b0;
    load_way0    = 1'b0;
    load_way1    = 1'b0;
    set_dirty0   = 1'b0;
    set_dirty1   = 1'b0;
    wb_way       = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = 16'h0000;
    hit_done     = 1'b0;
    miss_done    = 1'b0;

    // While reset is asserted every strobe stays low, even if a hitting
    // request is sitting on the inputs.
    if (rst_n) begin
      unique case (state_q)
        IDLE: begin
          if (req) begin
            if (hit0 | hit1) begin
              // Way 0 wins when both ways report a hit.
              mem_resp = 1'b1;
              load_lru = 1'b1;
              hit_done = 1'b1;
              if (hit0) begin
                set_one_hit = 1'b1;
                set_dirty0  = mem_write;
              end else begin
                set_two_hit = 1'b1;
                set_dirty1  = mem_write;
              end
            end else begin
              miss_done = 1'b1;
              state_d   = victim_dirty ? WRITEBACK : ALLOCATE;
            end
          end
        end

        WRITEBACK: begin
          pmem_write   = 1'b1;
          wb_way       = victim_q;
          pmem_address = {victim_tag_q, index, {OFFSET_W{1'b0}}};
          if (pmem_resp) begin
            state_d = ALLOCATE;
          end
        end

        ALLOCATE: begin
          pmem_read    = 1'b1;
          pmem_address = {mem_address[15:OFFSET_W], {OFFSET_W{1'b0}}};
          if (pmem_resp) begin
            load_way0 = ~victim_q;
            load_way1 = victim_q;
            state_d   = IDLE;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

endmodule
